// File: rtl/seq_counter_ctrl_if.sv
// Handshake/status bundle for seq_counter_ctrl; err exists only when SEQ_ERR_EN is defined.
interface seq_counter_ctrl_if #(
  parameter int PASS_W = 4,
  parameter int DIV_W  = 4
);
  logic              start;
  logic              pause;
  logic              abort;
  logic [PASS_W-1:0] passes;
  logic [DIV_W-1:0]  div;
  logic [2:0]        q;
  logic [2:0]        qb;
  logic              step;
  logic              wrap;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_cnt;
`ifdef SEQ_ERR_EN
  logic              err;

  modport master (
    output start, pause, abort, passes, div,
    input  q, qb, step, wrap, busy, done, pass_cnt, err
  );
  modport slave (
    input  start, pause, abort, passes, div,
    output q, qb, step, wrap, busy, done, pass_cnt, err
  );
`else
  modport master (
    output start, pause, abort, passes, div,
    input  q, qb, step, wrap, busy, done, pass_cnt
  );
  modport slave (
    input  start, pause, abort, passes, div,
    output q, qb, step, wrap, busy, done, pass_cnt
  );
`endif
endinterface

// File: rtl/seq_counter_ctrl.sv
// Run controller for the 1,2,3,5,7 sequence counter: start/pace/pause/abort runs of N passes.
// Optional sticky illegal-value flag err is enabled by defining SEQ_ERR_EN.
module seq_counter_ctrl #(
  parameter int PASS_W = 4,
  parameter int DIV_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  seq_counter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [2:0]        q_r, q_nxt_s;
  logic [2:0]        qb_r;
  logic              step_r, step_nxt_s;
  logic              wrap_r, wrap_nxt_s;
  logic              busy_r, done_r;
  logic [PASS_W-1:0] pass_cnt_r, pass_nxt_s;
  logic [PASS_W-1:0] passes_lat_r, passes_lat_nxt_s;
  logic [DIV_W-1:0]  div_lat_r, div_lat_nxt_s;
  logic [DIV_W-1:0]  presc_r, presc_nxt_s;
  logic [PASS_W-1:0] passes_eff_s;
  logic              more_passes_s;
`ifdef SEQ_ERR_EN
  logic              err_r, err_nxt_s;
`endif

  // Successor in the 1,2,3,5,7 sequence; anything outside it recovers to 1.
  function automatic logic [2:0] seq_next(input logic [2:0] v);
    logic [2:0] n;
    case (v)
      3'd1:    n = 3'd2;
      3'd2:    n = 3'd3;
      3'd3:    n = 3'd5;
      3'd5:    n = 3'd7;
      3'd7:    n = 3'd1;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic seq_legal(input logic [2:0] v);
    logic ok;
    case (v)
      3'd1, 3'd2, 3'd3, 3'd5, 3'd7: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-state and next-output computation; priority abort > start > pause > step.
  always_comb begin
    state_nxt_s      = state_r;
    q_nxt_s          = q_r;
    step_nxt_s       = 1'b0;
    wrap_nxt_s       = 1'b0;
    pass_nxt_s       = pass_cnt_r;
    passes_lat_nxt_s = passes_lat_r;
    div_lat_nxt_s    = div_lat_r;
    presc_nxt_s      = presc_r;
`ifdef SEQ_ERR_EN
    err_nxt_s        = err_r;
`endif
    if (passes_lat_r == {PASS_W{1'b0}}) begin
      passes_eff_s = PASS_W'(1);
    end else begin
      passes_eff_s = passes_lat_r;
    end
    // Widened by one bit so pass_cnt+1 cannot overflow in the compare.
    more_passes_s = (({1'b0, pass_cnt_r} + (PASS_W+1)'(1)) < {1'b0, passes_eff_s});

    if (bus.abort) begin
      state_nxt_s = IDLE;
      q_nxt_s     = 3'd0;
      pass_nxt_s  = {PASS_W{1'b0}};
      presc_nxt_s = {DIV_W{1'b0}};
`ifdef SEQ_ERR_EN
      err_nxt_s   = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            passes_lat_nxt_s = bus.passes;
            div_lat_nxt_s    = bus.div;
            q_nxt_s          = 3'd1;
            pass_nxt_s       = {PASS_W{1'b0}};
            presc_nxt_s      = {DIV_W{1'b0}};
            state_nxt_s      = RUN;
          end else begin
            state_nxt_s = state_r;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_nxt_s = PAUSE;
          end else if (presc_r == div_lat_r) begin
            step_nxt_s  = 1'b1;
            presc_nxt_s = {DIV_W{1'b0}};
            if (q_r == 3'd7) begin
              wrap_nxt_s = 1'b1;
              if (more_passes_s) begin
                pass_nxt_s = pass_cnt_r + PASS_W'(1);
                q_nxt_s    = 3'd1;
              end else begin
                pass_nxt_s  = passes_eff_s;
                q_nxt_s     = 3'd0;
                state_nxt_s = DONE;
              end
            end else if (seq_legal(q_r)) begin
              q_nxt_s = seq_next(q_r);
            end else begin
              q_nxt_s = 3'd1;
`ifdef SEQ_ERR_EN
              err_nxt_s = 1'b1;
`endif
            end
          end else begin
            presc_nxt_s = presc_r + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (bus.pause) begin
            state_nxt_s = PAUSE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          q_nxt_s     = 3'd0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      q_r          <= 3'd0;
      qb_r         <= 3'b111;
      step_r       <= 1'b0;
      wrap_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_cnt_r   <= {PASS_W{1'b0}};
      passes_lat_r <= {PASS_W{1'b0}};
      div_lat_r    <= {DIV_W{1'b0}};
      presc_r      <= {DIV_W{1'b0}};
`ifdef SEQ_ERR_EN
      err_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      q_r          <= q_nxt_s;
      qb_r         <= ~q_nxt_s;
      step_r       <= step_nxt_s;
      wrap_r       <= wrap_nxt_s;
      busy_r       <= (state_nxt_s == RUN) || (state_nxt_s == PAUSE);
      done_r       <= (state_nxt_s == DONE);
      pass_cnt_r   <= pass_nxt_s;
      passes_lat_r <= passes_lat_nxt_s;
      div_lat_r    <= div_lat_nxt_s;
      presc_r      <= presc_nxt_s;
`ifdef SEQ_ERR_EN
      err_r        <= err_nxt_s;
`endif
    end
  end

  assign bus.q        = q_r;
  assign bus.qb       = qb_r;
  assign bus.step     = step_r;
  assign bus.wrap     = wrap_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass_cnt = pass_cnt_r;
`ifdef SEQ_ERR_EN
  assign bus.err      = err_r;
`endif

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Self-checking bench for seq_counter_ctrl: vector table plus hand sequences, scoreboard queue.
module tb_seq_counter_ctrl;

  typedef struct packed {
    logic [2:0] q;
    logic       step;
    logic       wrap;
    logic       busy;
    logic       done;
    logic [3:0] pass_cnt;
  } exp_t;

  typedef struct {
    logic       start;
    logic       pause;
    logic       abort;
    logic [3:0] passes;
    logic [3:0] div;
    exp_t       e;
  } vec_t;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  vec_t tbl[20];
  logic [2:0] seq[5];

  seq_counter_ctrl_if #(.PASS_W(4), .DIV_W(4)) bus ();

  seq_counter_ctrl #(.PASS_W(4), .DIV_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [2:0] q, input logic st, input logic wr,
                              input logic bz, input logic dn, input logic [3:0] pc);
    exp_t e;
    e.q = q; e.step = st; e.wrap = wr; e.busy = bz; e.done = dn; e.pass_cnt = pc;
    return e;
  endfunction

  function automatic vec_t mkv(input logic st, input logic pa, input logic ab,
                               input logic [3:0] ps, input logic [3:0] dv, input exp_t e);
    vec_t v;
    v.start = st; v.pause = pa; v.abort = ab; v.passes = ps; v.div = dv; v.e = e;
    return v;
  endfunction

  task automatic check_now(input string name, input exp_t e);
    logic [13:0] act;
    logic [13:0] req;
    act = {bus.q, bus.qb, bus.step, bus.wrap, bus.busy, bus.done, bus.pass_cnt};
    req = {e.q, ~e.q, e.step, e.wrap, e.busy, e.done, e.pass_cnt};
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got q=%b qb=%b step=%b wrap=%b busy=%b done=%b pass_cnt=%0d, want q=%b qb=%b step=%b wrap=%b busy=%b done=%b pass_cnt=%0d",
               name, bus.q, bus.qb, bus.step, bus.wrap, bus.busy, bus.done, bus.pass_cnt,
               e.q, ~e.q, e.step, e.wrap, e.busy, e.done, e.pass_cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cyc(input logic st, input logic pa, input logic ab,
                     input logic [3:0] ps, input logic [3:0] dv,
                     input exp_t e, input string name);
    exp_t got;
    bus.start = st; bus.pause = pa; bus.abort = ab; bus.passes = ps; bus.div = dv;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got none, want one entry", name);
    end else begin
      got = sb.pop_front();
      check_now(name, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd3; seq[3] = 3'd5; seq[4] = 3'd7;

    // div=0 passes=2 run, then passes=0 run, start-while-busy, abort+start in DONE
    tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 4'd2, 4'd0, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[1]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[2]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[3]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[5]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1));
    tbl[6]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1));
    tbl[7]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1));
    tbl[8]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1));
    tbl[9]  = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1));
    tbl[10] = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2));
    tbl[11] = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2));
    tbl[12] = mkv(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[13] = mkv(1'b1, 1'b0, 1'b0, 4'd5, 4'd3, mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[14] = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[15] = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[16] = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl[17] = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1));
    tbl[18] = mkv(1'b1, 1'b0, 1'b1, 4'd3, 4'd0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    tbl[19] = mkv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0; bus.passes = 4'd0; bus.div = 4'd0;
    reset = 1'b1;
    #2;
    check_now("reset_state", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].start, tbl[i].pause, tbl[i].abort, tbl[i].passes, tbl[i].div,
          tbl[i].e, $sformatf("table[%0d]", i));
    end

    // div=2 passes=1: q advances every 3 clocks, done on the 15th edge
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "div2_start");
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(seq[i-1], 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "div2_hold_a");
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(seq[i-1], 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "div2_hold_b");
      if (i < 5) begin
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(seq[i], 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "div2_step");
      end else begin
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1), "div2_done");
      end
    end

    // pause 5 clocks at q=3 with prescaler mid-count, then resume
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_start");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_h1");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_h2");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "pz_q2");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_h3");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_h4");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "pz_q3");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_h5");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_frozen");
    end
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_release");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "pz_remain");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "pz_q5");

    // abort together with pause while q=5
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "abort_pause");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "idle_after_abort");

    // asynchronous reset between edges while q=5
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "rst_start");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "rst_q2");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "rst_q3");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "rst_q5");
    #2 reset = 1'b1;
    #1;
    check_now("async_reset", mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    #2 reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "idle_after_reset");

`ifdef SEQ_ERR_EN
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, mk(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "err_start");
    force dut.q_r = 3'b110;
    #1 release dut.q_r;
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "err_recover");
    n_tests++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b, want 1", bus.err);
    end
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, mk(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0), "err_run");
    n_tests++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, want 1", bus.err);
    end
    cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "err_abort");
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b, want 0", bus.err);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
